// File: rtl/sw_debouncer_pkg.sv
// Shared definitions for the slide-switch debouncer.
//   - 3-bit debounce FSM state encodings. Bit 2 is set exactly in the states
//     where the debounced level is 1 (ONE, W0_1..W0_3), so the level decode is
//     a single bit.
//   - Default tick counter width (2^19 cycles is ~10.5 ms at 50 MHz).
//   - Helper that maps a state onto its debounced level.
package sw_debouncer_pkg;

  typedef logic [2:0] db_state_t;

  localparam logic [2:0] ST_ZERO = 3'd0;
  localparam logic [2:0] ST_W1_1 = 3'd1;
  localparam logic [2:0] ST_W1_2 = 3'd2;
  localparam logic [2:0] ST_W1_3 = 3'd3;
  localparam logic [2:0] ST_ONE  = 3'd4;
  localparam logic [2:0] ST_W0_1 = 3'd5;
  localparam logic [2:0] ST_W0_2 = 3'd6;
  localparam logic [2:0] ST_W0_3 = 3'd7;

  localparam int TICK_W_DEFAULT = 19;

  // Debounced level held while the FSM sits in the given state.
  function automatic logic level_of(input db_state_t st);
    return st[2];
  endfunction

endpackage

// File: rtl/sw_debouncer_db_fsm.sv
// Per-channel debounce FSM.
//   clk   in  rising-edge clock
//   reset in  synchronous active-high reset, returns the FSM to ZERO
//   s     in  synchronized switch level
//   tick  in  shared qualification tick, one cycle every P clocks
//   db    out registered debounced level (follows the pulses by one cycle)
//   rise  out registered 1-cycle pulse on the ZERO-side -> ONE transition
//   fall  out registered 1-cycle pulse on the ONE-side -> ZERO transition
// A level change is accepted only after the new value has been seen
// continuously across three ticks; any reversal drops back to the old
// stable state and qualification starts over.
module sw_debouncer_db_fsm
  import sw_debouncer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  db_state_t state_reg, state_next;
  logic      db_reg;
  logic      rise_reg, rise_next;
  logic      fall_reg, fall_next;

  // A reversal of s is tested before tick in every waiting state, so a
  // reversal coinciding with a tick never advances the FSM.
  always_comb begin
    state_next = state_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      ST_ZERO: begin
        if (s) state_next = ST_W1_1;
      end
      ST_W1_1, ST_W1_2: begin
        if (!s)        state_next = ST_ZERO;
        else if (tick) state_next = state_reg + 3'd1;
      end
      ST_W1_3: begin
        if (!s) begin
          state_next = ST_ZERO;
        end else if (tick) begin
          state_next = ST_ONE;
          rise_next  = 1'b1;
        end
      end
      ST_ONE: begin
        if (!s) state_next = ST_W0_1;
      end
      ST_W0_1, ST_W0_2: begin
        if (s)         state_next = ST_ONE;
        else if (tick) state_next = state_reg + 3'd1;
      end
      ST_W0_3: begin
        if (s) begin
          state_next = ST_ONE;
        end else if (tick) begin
          state_next = ST_ZERO;
          fall_next  = 1'b1;
        end
      end
      default: state_next = ST_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_ZERO;
      db_reg    <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Decoded from the current state, so db moves one cycle after the pulse.
      db_reg    <= level_of(state_reg);
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign db   = db_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/sw_debouncer.sv
// Slide-switch conditioner in front of the rotating-square core.
//   clk     in  rising-edge system clock
//   reset   in  synchronous active-high reset
//   sw_raw  in  [N] asynchronous raw switch pins
//   sw_db   out [N] debounced levels (sw_db[1] -> en, sw_db[0] -> cw)
//   sw_rise out [N] 1-cycle pulse when sw_db goes 0->1
//   sw_fall out [N] 1-cycle pulse when sw_db goes 1->0
//   tick    out shared qualification tick, 1 cycle every 2^TICK_W clocks
// Each channel gets a 2-flop synchronizer and its own debounce FSM; the only
// shared resource is the free-running tick counter.
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int N      = 2,
  parameter int TICK_W = TICK_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         tick
);

  logic [N-1:0]      sync1_reg;
  logic [N-1:0]      sync2_reg;
  logic [TICK_W-1:0] tick_cnt_reg;

  // Two-stage synchronizer; the raw pins never reach the FSMs directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Free-running counter; wraps naturally at 2^TICK_W.
  always_ff @(posedge clk) begin
    if (reset) tick_cnt_reg <= '0;
    else       tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  assign tick = &tick_cnt_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : gen_ch
      sw_debouncer_db_fsm u_fsm (
        .clk   (clk),
        .reset (reset),
        .s     (sync2_reg[gi]),
        .tick  (tick),
        .db    (sw_db[gi]),
        .rise  (sw_rise[gi]),
        .fall  (sw_fall[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with TICK_W=4 (P=16 cycles).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sw_debouncer;
  import sw_debouncer_pkg::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_db;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic         tick;

  int n_cmp = 0;
  int n_bad = 0;

  sw_debouncer #(.N(N), .TICK_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps until the selected pulse appears on channel ch. n = steps taken
  // (-1 on timeout); stray = pulses of any kind seen before the hit.
  task automatic wait_pulse(input bit want_fall, input int ch, input int max_steps,
                            output int n, output int stray);
    logic [N-1:0] p;
    n = -1;
    stray = 0;
    for (int k = 1; k <= max_steps; k++) begin
      step();
      p = want_fall ? sw_fall : sw_rise;
      if (p[ch]) begin
        n = k;
        break;
      end
      if ((|sw_rise) || (|sw_fall)) stray++;
    end
  endtask

  // Latency in cycles, counted from the first edge that samples the raw change.
  function automatic logic lat_ok(input int n);
    return (n - 1 >= 35) && (n - 1 <= 50);
  endfunction

  int n, stray, bad;

  initial begin
    // ---- 1: reset held with switches high, then both qualify together
    reset  = 1'b1;
    sw_raw = 2'b11;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_rst_outputs", {27'd0, sw_db, sw_rise, sw_fall, tick}, 32'd0);
    end
    reset = 1'b0;
    wait_pulse(1'b0, 0, 60, n, stray);
    chk("t1_rise_found", n != -1, 1);
    chk("t1_rise_latency", lat_ok(n), 1);
    chk("t1_rise_both", sw_rise, 2'b11);
    chk("t1_db_at_pulse", sw_db, 2'b00);
    chk("t1_stray", stray, 0);
    step();
    chk("t1_rise_one_cycle", sw_rise, 2'b00);
    chk("t1_db_after", sw_db, 2'b11);

    // ---- 2: bounce on channel 0, then a clean hold
    reset  = 1'b1;
    sw_raw = 2'b00;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      sw_raw[0] = ((k / 5) % 2) == 0;
      step();
      if ((|sw_rise) || (|sw_fall) || (|sw_db)) bad++;
    end
    chk("t2_bounce_quiet", bad, 0);
    sw_raw[0] = 1'b1;
    wait_pulse(1'b0, 0, 60, n, stray);
    chk("t2_rise_found", n != -1, 1);
    chk("t2_rise_latency", lat_ok(n), 1);
    chk("t2_rise_ch0_only", sw_rise, 2'b01);
    chk("t2_stray", stray, 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if ((|sw_rise) || (|sw_fall)) bad++;
    end
    chk("t2_single_rise", bad, 0);
    chk("t2_db", sw_db, 2'b01);

    // ---- 3: one-cycle glitch on channel 1
    sw_raw[1] = 1'b1;
    step();
    sw_raw[1] = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if ((sw_db != 2'b01) || (|sw_rise) || (|sw_fall)) bad++;
    end
    chk("t3_glitch_ignored", bad, 0);

    // ---- 4: channel 0 falls while channel 1 chatters low
    sw_raw[1] = 1'b1;
    wait_pulse(1'b0, 1, 60, n, stray);
    chk("t4_ch1_rise_found", n != -1, 1);
    step();
    chk("t4_db_both", sw_db, 2'b11);
    sw_raw[0] = 1'b0;
    n = -1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 3 == 0) sw_raw[1] = ~sw_raw[1];
      step();
      if (!sw_db[1] || sw_fall[1] || (|sw_rise)) bad++;
      if (sw_fall[0]) begin
        n = k + 1;
        break;
      end
    end
    chk("t4_fall_found", n != -1, 1);
    chk("t4_fall_latency", lat_ok(n), 1);
    chk("t4_ch1_steady", bad, 0);
    sw_raw[1] = 1'b1;
    step();
    chk("t4_db_after", sw_db, 2'b10);

    // ---- 5: reset in the middle of qualification
    reset  = 1'b1;
    sw_raw = 2'b00;
    for (int k = 0; k < 3; k++) step();
    reset     = 1'b0;
    sw_raw[0] = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("t5_state_w1_2", dut.gen_ch[0].u_fsm.state_reg, ST_W1_2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_state_zero", dut.gen_ch[0].u_fsm.state_reg, ST_ZERO);
    chk("t5_outputs_clear", {sw_db, sw_rise, sw_fall}, 6'd0);
    wait_pulse(1'b0, 0, 60, n, stray);
    chk("t5_requal_found", n != -1, 1);
    chk("t5_requal_latency", lat_ok(n), 1);
    chk("t5_stray", stray, 0);

    // ---- 6: reversal coinciding with a tick in W1_2
    reset  = 1'b1;
    sw_raw = 2'b00;
    for (int k = 0; k < 3; k++) step();
    reset     = 1'b0;
    sw_raw[0] = 1'b1;
    for (int k = 0; k < 29; k++) step();
    chk("t6_state_w1_2", dut.gen_ch[0].u_fsm.state_reg, ST_W1_2);
    sw_raw[0] = 1'b0;
    step();
    step();
    chk("t6_tick_now", tick, 1);
    step();
    chk("t6_state_zero", dut.gen_ch[0].u_fsm.state_reg, ST_ZERO);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if ((|sw_db) || (|sw_rise) || (|sw_fall)) bad++;
    end
    chk("t6_no_output", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
